// File: rtl/prescaled_counter.sv
// prescaled_counter: up/down wrap/saturate counter stepped by a free-running prescaler
// Ports: CLK clock, RST sync active-high reset, en advance enable, dir 0 up/1 down,
//   sat 0 wrap/1 saturate, clr sync clear, count registered value,
//   tick one-cycle step pulse, limit one-cycle pulse for a step taken at the limit.
// Optional macro PRESCALED_COUNTER_LOAD_EN adds load_valid/load_value/load_ready.
module prescaled_counter #(
  parameter int WIDTH    = 4,
  parameter int DIV_MAX  = 2097151,
  parameter int DIV_BITS = (DIV_MAX == 0) ? 1 : $clog2(DIV_MAX + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             clr,
`ifdef PRESCALED_COUNTER_LOAD_EN
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             limit
);
  localparam logic [DIV_BITS-1:0] DIV_TERM = DIV_BITS'(DIV_MAX);
  logic [DIV_BITS-1:0] r_div;
  logic [WIDTH-1:0]    r_count;
  logic                r_tick;
  logic                r_limit;
  logic                w_step;
  logic                w_at_lim;
  logic                w_load;
  logic [WIDTH-1:0]    w_load_value;
  logic [WIDTH-1:0]    w_next;
`ifdef PRESCALED_COUNTER_LOAD_EN
  assign load_ready   = !RST && !clr;
  assign w_load       = load_valid && load_ready;
  assign w_load_value = load_value;
`else
  assign w_load       = 1'b0;
  assign w_load_value = '0;
`endif
  assign w_step   = en && (r_div == DIV_TERM);
  assign w_at_lim = dir ? (r_count == '0) : (r_count == '1);
  // saturate blocks the step at the limit; wrap relies on modulo arithmetic
  assign w_next   = (sat && w_at_lim) ? r_count
                  : dir ? r_count - WIDTH'(1) : r_count + WIDTH'(1);
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      r_div   <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_limit <= 1'b0;
    end else begin
      if (en) r_div <= (r_div == DIV_TERM) ? '0 : r_div + DIV_BITS'(1);
      r_count <= w_load ? w_load_value : w_step ? w_next : r_count;
      r_tick  <= w_step && !w_load;
      r_limit <= w_step && w_at_lim && !w_load;
    end
  end
  assign count = r_count;
  assign tick  = r_tick;
  assign limit = r_limit;
endmodule

// File: tb/tb_prescaled_counter.sv
// tb_prescaled_counter: directed checks of prescaled_counter with DIV_MAX=0 and DIV_MAX=3
module tb_prescaled_counter;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  int checks = 0;
  int errors = 0;
  logic rst0 = 1'b1, en0 = 1'b0, dir0 = 1'b0, sat0 = 1'b0, clr0 = 1'b0;
  logic rst3 = 1'b1, en3 = 1'b0, dir3 = 1'b0, sat3 = 1'b0, clr3 = 1'b0;
  logic [3:0] cnt0, cnt3;
  logic tick0, tick3, lim0, lim3;
`ifdef PRESCALED_COUNTER_LOAD_EN
  logic lv0 = 1'b0, lv3 = 1'b0, lr0, lr3;
  logic [3:0] lval0 = 4'h0, lval3 = 4'h0;
`endif
  prescaled_counter #(.WIDTH(4), .DIV_MAX(0)) u_d0 (
    .CLK(CLK), .RST(rst0), .en(en0), .dir(dir0), .sat(sat0), .clr(clr0),
`ifdef PRESCALED_COUNTER_LOAD_EN
    .load_valid(lv0), .load_value(lval0), .load_ready(lr0),
`endif
    .count(cnt0), .tick(tick0), .limit(lim0)
  );
  prescaled_counter #(.WIDTH(4), .DIV_MAX(3)) u_d3 (
    .CLK(CLK), .RST(rst3), .en(en3), .dir(dir3), .sat(sat3), .clr(clr3),
`ifdef PRESCALED_COUNTER_LOAD_EN
    .load_valid(lv3), .load_value(lval3), .load_ready(lr3),
`endif
    .count(cnt3), .tick(tick3), .limit(lim3)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    cyc();
    chk("rst0_count", cnt0, 0);
    chk("rst0_tick", tick0, 0);
    chk("rst0_limit", lim0, 0);
    chk("rst3_count", cnt3, 0);
    rst0 = 1'b0;
    en0 = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      chk($sformatf("wrap_count%0d", i), cnt0, i % 16);
      chk($sformatf("wrap_tick%0d", i), tick0, 1);
      chk($sformatf("wrap_limit%0d", i), lim0, (i == 16) ? 1 : 0);
    end
    clr0 = 1'b1;
    cyc();
    chk("clr_count", cnt0, 0);
    chk("clr_tick", tick0, 0);
    chk("clr_limit", lim0, 0);
    clr0 = 1'b0;
    dir0 = 1'b1;
    sat0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("satdn_count", cnt0, 0);
      chk("satdn_tick", tick0, 1);
      chk("satdn_limit", lim0, 1);
    end
    sat0 = 1'b0;
    cyc();
    chk("wrapdn_count", cnt0, 15);
    chk("wrapdn_limit", lim0, 1);
    dir0 = 1'b0;
    sat0 = 1'b1;
    cyc();
    chk("satup_count", cnt0, 15);
    chk("satup_limit", lim0, 1);
    chk("satup_tick", tick0, 1);
    dir0 = 1'b1;
    cyc();
    chk("dn_count", cnt0, 14);
    chk("dn_limit", lim0, 0);
    en0 = 1'b0;
    cyc();
    cyc();
    chk("hold_count", cnt0, 14);
    chk("hold_tick", tick0, 0);
    chk("hold_limit", lim0, 0);
`ifdef PRESCALED_COUNTER_LOAD_EN
    en0 = 1'b1;
    dir0 = 1'b0;
    sat0 = 1'b0;
    lv0 = 1'b1;
    lval0 = 4'hA;
    #1;
    chk("load_ready", lr0, 1);
    cyc();
    chk("load_count", cnt0, 4'hA);
    chk("load_tick", tick0, 0);
    chk("load_limit", lim0, 0);
    en0 = 1'b0;
    lval0 = 4'h5;
    cyc();
    chk("load_noen_count", cnt0, 4'h5);
    clr0 = 1'b1;
    lval0 = 4'hA;
    #1;
    chk("load_clr_ready", lr0, 0);
    cyc();
    chk("load_clr_count", cnt0, 0);
    clr0 = 1'b0;
    rst0 = 1'b1;
    #1;
    chk("load_rst_ready", lr0, 0);
    cyc();
    chk("load_rst_count", cnt0, 0);
    lv0 = 1'b0;
    rst0 = 1'b0;
`endif
    rst3 = 1'b0;
    en3 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk($sformatf("pre_tick%0d", i), tick3, (i % 4 == 0) ? 1 : 0);
      chk($sformatf("pre_count%0d", i), cnt3, i / 4);
    end
    cyc();
    cyc();
    en3 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("frz_count", cnt3, 2);
      chk("frz_tick", tick3, 0);
    end
    en3 = 1'b1;
    cyc();
    chk("resume_tick_a", tick3, 0);
    cyc();
    chk("resume_tick_b", tick3, 1);
    chk("resume_count", cnt3, 3);
    cyc();
    cyc();
    rst3 = 1'b1;
    cyc();
    chk("midrst_count", cnt3, 0);
    chk("midrst_tick", tick3, 0);
    chk("midrst_limit", lim3, 0);
    rst3 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("post_tick%0d", i), tick3, (i == 4) ? 1 : 0);
      chk($sformatf("post_count%0d", i), cnt3, (i == 4) ? 1 : 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prescaled_counter.md
PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 1..32.
REQ-002 SHALL have parameter DIV_MAX, default 2097151: prescaler terminal value; step period is DIV_MAX+1 cycles; 0 means a step every enabled cycle.
REQ-003 SHALL have parameter DIV_BITS, default $clog2(DIV_MAX+1) with a floor of 1: prescaler register width.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: prescaler and counter advance only while high.
REQ-007 SHALL have port dir, input, 1 bit: 0 counts up, 1 counts down.
REQ-008 SHALL have port sat, input, 1 bit: 0 wraps at the limit, 1 saturates at the limit.
REQ-009 SHALL have port clr, input, 1 bit: synchronous clear of the count and prescaler.
REQ-010 SHALL have port load_valid, input, 1 bit: load request (PRESCALED_COUNTER_LOAD_EN only).
REQ-011 SHALL have port load_value, input, WIDTH bits: value to load (PRESCALED_COUNTER_LOAD_EN only).
REQ-012 SHALL have port load_ready, output, 1 bit: load acceptance (PRESCALED_COUNTER_LOAD_EN only).
REQ-013 SHALL have port count, output, WIDTH bits: registered counter value.
REQ-014 SHALL have port tick, output, 1 bit: registered one-cycle pulse for every step taken.
REQ-015 SHALL have port limit, output, 1 bit: registered one-cycle pulse when a step occurs while count is at its directional limit (all-ones up, zero down).

Function
REQ-016 Prescaler SHALL increment each cycle en=1; at DIV_MAX it SHALL return to 0 and generate a step in that same cycle.
REQ-017 While en=0, prescaler and count SHALL hold, and tick and limit SHALL be 0.
REQ-018 On a step in wrap mode, count SHALL become count±1 modulo 2^WIDTH.
REQ-019 On a step in saturate mode at the limit, count SHALL hold its value.
REQ-020 tick and limit SHALL go high in the cycle after the step, together with the updated count (1-cycle latency).
REQ-021 limit SHALL pulse for a step at the limit in both modes (wrap event or blocked saturate).
REQ-022 dir and sat SHALL be sampled on the step cycle only; changing them between steps has no other effect.
REQ-023 Priority SHALL be RST > clr > load > step.
REQ-024 clr=1 SHALL zero count and prescaler and suppress tick and limit, regardless of en.
REQ-025 load_ready SHALL be combinational !RST && !clr.
REQ-026 A load is accepted when load_valid && load_ready: count SHALL become load_value next cycle, prescaler SHALL be unaffected, any coincident step SHALL be dropped, and tick and limit SHALL be 0.
REQ-027 A load SHALL be accepted independent of en.

Reset
REQ-028 RST=1 at a rising edge SHALL set count, prescaler, tick and limit to 0; load_ready SHALL be 0 during RST.
REQ-029 Reset mid-prescale SHALL discard partial prescaler progress; the first step after release occurs DIV_MAX+1 enabled cycles later.

Configuration
REQ-030 With macro PRESCALED_COUNTER_LOAD_EN defined, the load_valid, load_value and load_ready ports and load behaviour SHALL exist.
REQ-031 Without PRESCALED_COUNTER_LOAD_EN, those three ports SHALL be absent and priority SHALL reduce to RST > clr > step.

Verification
REQ-032 WIDTH=4, DIV_MAX=0, en=1, dir=0, sat=0, 17 cycles after reset -> count 1..15, 0, 1; limit pulses once, on the cycle count shows 0.
REQ-033 WIDTH=4, DIV_MAX=3, en=1 -> tick every 4th cycle; count increments only then; en=0 for 10 cycles -> count and prescaler frozen.
REQ-034 DIV_MAX=0, dir=1, sat=1, starting at 0 -> count stays 0; limit pulses every cycle; tick still pulses.
REQ-035 Load enabled: load_valid=1 with load_value=4'hA on a step cycle -> count=A next cycle, tick=0; load with clr=1 -> load_ready=0, count=0.
REQ-036 DIV_MAX=3, RST asserted at prescaler=2 -> all outputs 0 next cycle; first tick occurs 4 enabled cycles after release.
